// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between instruction fetch (IF) and the
// load/store unit (D). Ties are broken round-robin. D can lock the port
// for atomic read-modify-write, and a forced release kicks in after
// LOCK_MAX locked cycles. A small tag pipeline, matched to the RAM read
// latency, routes each read response back to the port that issued it.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int LOCK_MAX    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    // instruction fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // data (load/store) port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic                d_lock,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                lock_err,
    // RAM side
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [0:0] ST_RR     = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Last counter value seen inside LOCKED before the forced release fires.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic             last_gnt;
    logic             last_gnt_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic             forced_release;

    logic             gnt_if;
    logic             gnt_d;
    logic             push_valid;

    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [MEM_LATENCY-1:0] pipe_port;
    logic                   head_valid;
    logic                   head_port;

    // Grant decision: one winner per cycle, locked D excludes IF, and reset blocks all grants.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (reset_n) begin
            if (state == ST_LOCKED) begin
                gnt_d = d_req;
            end else if (if_req && d_req) begin
                if (last_gnt == PORT_D) begin
                    gnt_if = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_if = if_req;
                gnt_d  = d_req;
            end
        end
    end

    // Next-state logic for the RR/LOCKED FSM, the round-robin pointer and the lock timer.
    always_comb begin
        state_next     = state;
        last_gnt_next  = last_gnt;
        lock_cnt_next  = lock_cnt;
        forced_release = 1'b0;

        if (gnt_if) begin
            last_gnt_next = PORT_IF;
        end
        if (gnt_d) begin
            last_gnt_next = PORT_D;
        end

        case (state)
            ST_RR: begin
                if (gnt_d && d_lock) begin
                    state_next    = ST_LOCKED;
                    lock_cnt_next = '0;
                end
            end
            ST_LOCKED: begin
                if (gnt_d && !d_lock) begin
                    state_next    = ST_RR;
                    lock_cnt_next = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_next     = ST_RR;
                    lock_cnt_next  = '0;
                    last_gnt_next  = PORT_D;
                    forced_release = reset_n;
                end else begin
                    lock_cnt_next = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next    = ST_RR;
                lock_cnt_next = '0;
            end
        endcase
    end

    // FSM, round-robin pointer and lock timer registers; the pointer starts at D so IF wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RR;
            last_gnt <= PORT_D;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // A grant that expects read data pushes a valid tag; writes and idle cycles push bubbles.
    always_comb begin
        push_valid = gnt_if | (gnt_d & ~d_we);
    end

    // Tag shift register, MEM_LATENCY deep, so the head lines up with mem_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_port  <= '0;
        end else begin
            pipe_valid[0] <= push_valid;
            pipe_port[0]  <= gnt_d;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_port[i]  <= pipe_port[i-1];
            end
        end
    end

    // Steer the returning read data to the issuing port and zero the other port's data bus.
    always_comb begin
        head_valid = pipe_valid[MEM_LATENCY-1];
        head_port  = pipe_port[MEM_LATENCY-1];
        if_rvalid  = head_valid && (head_port == PORT_IF);
        d_rvalid   = head_valid && (head_port == PORT_D);
        if_rdata   = if_rvalid ? mem_rdata : '0;
        d_rdata    = d_rvalid  ? mem_rdata : '0;
    end

    // Drive the RAM from whichever port won; everything is zero when nobody did.
    always_comb begin
        mem_en    = gnt_if | gnt_d;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_d) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (gnt_if) begin
            mem_be    = {BE_W{1'b1}};
            mem_addr  = if_addr;
        end
    end

    // Export grants and the forced-release pulse.
    always_comb begin
        if_gnt   = gnt_if;
        d_gnt    = gnt_d;
        lock_err = forced_release;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic. The expected outputs
// come from a transaction-level model: a "who owns the port" notion, a
// locked-cycle tally and a queue of outstanding reads that carry due cycles.
module tb_mem_port_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int MEM_LATENCY = 2;
    localparam int LOCK_MAX    = 5;

    logic              clk;
    logic              reset_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              lock_err;
    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_LATENCY(MEM_LATENCY), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_lock(d_lock),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .lock_err(lock_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit toD;
    } resp_t;

    int    checks = 0;
    int    failures = 0;
    int    cycle = 0;
    int    lockErrSeen = 0;
    resp_t pending[$];

    bit ownerIsLockedD;
    int lockedCycles;
    bit dWonLast;
    bit lastExpIf;
    bit lastExpD;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic clearModel();
        pending.delete();
        ownerIsLockedD = 1'b0;
        lockedCycles   = 0;
        dWonLast       = 1'b1;
        lastExpIf      = 1'b0;
        lastExpD       = 1'b0;
    endtask

    // Drive one cycle at the falling edge, compare settled outputs, then advance the model.
    task automatic applyStimulus(input bit ir, input logic [ADDR_W-1:0] ia,
                                 input bit dr, input bit dwe, input logic [BE_W-1:0] dbe,
                                 input bit dlk, input logic [ADDR_W-1:0] da,
                                 input logic [DATA_W-1:0] dw);
        bit              expIf;
        bit              expD;
        bit              expErr;
        bit              expIfRv;
        bit              expDRv;
        logic [DATA_W-1:0] rd;
        if_req  = ir;  if_addr = ia;
        d_req   = dr;  d_we    = dwe; d_be = dbe; d_lock = dlk;
        d_addr  = da;  d_wdata = dw;
        rd      = $urandom;
        mem_rdata = rd;
        #1;

        expIf = 1'b0;
        expD  = 1'b0;
        if (ownerIsLockedD) expD = dr;
        else if (ir && dr) begin
            expIf = dWonLast;
            expD  = !dWonLast;
        end else begin
            expIf = ir;
            expD  = dr;
        end
        expErr = ownerIsLockedD && !(expD && !dlk) && (lockedCycles + 1 == LOCK_MAX);

        expIfRv = 1'b0;
        expDRv  = 1'b0;
        if (pending.size() > 0 && pending[0].due == cycle) begin
            expIfRv = !pending[0].toD;
            expDRv  = pending[0].toD;
            void'(pending.pop_front());
        end

        checkOutput("if_gnt",    64'(if_gnt),    64'(expIf));
        checkOutput("d_gnt",     64'(d_gnt),     64'(expD));
        checkOutput("mem_en",    64'(mem_en),    64'(expIf | expD));
        checkOutput("mem_we",    64'(mem_we),    64'(expD & dwe));
        checkOutput("mem_be",    64'(mem_be),    expD ? 64'(dbe) : (expIf ? 64'hF : 64'h0));
        checkOutput("mem_addr",  64'(mem_addr),  expD ? 64'(da) : (expIf ? 64'(ia) : 64'h0));
        checkOutput("mem_wdata", 64'(mem_wdata), expD ? 64'(dw) : 64'h0);
        checkOutput("lock_err",  64'(lock_err),  64'(expErr));
        checkOutput("if_rvalid", 64'(if_rvalid), 64'(expIfRv));
        checkOutput("d_rvalid",  64'(d_rvalid),  64'(expDRv));
        checkOutput("if_rdata",  64'(if_rdata),  expIfRv ? 64'(rd) : 64'h0);
        checkOutput("d_rdata",   64'(d_rdata),   expDRv ? 64'(rd) : 64'h0);
        if (lock_err === 1'b1) lockErrSeen++;

        if (expIf || (expD && !dwe)) pending.push_back('{due: cycle + MEM_LATENCY, toD: expD});
        if (expIf) dWonLast = 1'b0;
        if (expD)  dWonLast = 1'b1;
        if (!ownerIsLockedD) begin
            if (expD && dlk) begin
                ownerIsLockedD = 1'b1;
                lockedCycles   = 0;
            end
        end else begin
            lockedCycles++;
            if (expD && !dlk) ownerIsLockedD = 1'b0;
            else if (lockedCycles == LOCK_MAX) begin
                ownerIsLockedD = 1'b0;
                dWonLast       = 1'b1;
            end
        end
        lastExpIf = expIf;
        lastExpD  = expD;

        @(negedge clk);
        cycle++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, 0, '0, '0);
    endtask

    // Hold reset across a couple of edges with both ports requesting; nothing may leak out.
    task automatic applyReset();
        reset_n = 1'b0;
        if_req  = 1'b1; d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("rst_if_gnt",    64'(if_gnt),    64'h0);
            checkOutput("rst_d_gnt",     64'(d_gnt),     64'h0);
            checkOutput("rst_mem_en",    64'(mem_en),    64'h0);
            checkOutput("rst_if_rvalid", 64'(if_rvalid), 64'h0);
            checkOutput("rst_d_rvalid",  64'(d_rvalid),  64'h0);
            checkOutput("rst_lock_err",  64'(lock_err),  64'h0);
            @(negedge clk);
            cycle++;
        end
        clearModel();
        reset_n = 1'b1;
    endtask

    initial begin
        bit              ir, dr, dwe, dlk;
        logic [ADDR_W-1:0] ia, da;
        logic [BE_W-1:0]   dbe;
        logic [DATA_W-1:0] dw;

        reset_n = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_lock = 0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        clearModel();
        @(negedge clk);
        applyReset();

        $display("[TB] single fetch");
        applyStimulus(1, 32'h100, 0, 0, '0, 0, '0, '0);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] contended reads alternate");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 32'h1000 + 32'(i * 4), 1, 0, 4'hF, 0, 32'h2000 + 32'(i * 4), '0);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] partial data write");
        applyStimulus(0, '0, 1, 1, 4'b0011, 0, 32'h200, 32'hDEADBEEF);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] locked read-modify-write");
        applyStimulus(0, '0, 1, 0, 4'hF, 1, 32'h300, '0);
        applyStimulus(1, 32'h400, 1, 0, 4'hF, 1, 32'h300, '0);
        applyStimulus(1, 32'h400, 0, 0, '0, 0, '0, '0);
        applyStimulus(1, 32'h400, 1, 1, 4'hF, 0, 32'h300, 32'h12345678);
        applyStimulus(1, 32'h400, 1, 0, 4'hF, 0, 32'h304, '0);
        checkOutput("ifAfterUnlock", 64'(lastExpIf), 64'h1);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] forced lock release");
        lockErrSeen = 0;
        applyStimulus(0, '0, 1, 0, 4'hF, 1, 32'h500, '0);
        for (int i = 0; i < LOCK_MAX + 2; i++) applyStimulus(1, 32'h600, 0, 0, '0, 0, '0, '0);
        checkOutput("lockErrCount", 64'(lockErrSeen), 64'd1);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] reset with read in flight");
        applyStimulus(1, 32'h700, 0, 0, '0, 0, '0, '0);
        applyStimulus(1, 32'h700, 1, 0, 4'hF, 1, 32'h704, '0);
        applyReset();
        idleCycles(MEM_LATENCY + 1);
        applyStimulus(1, 32'h800, 1, 0, 4'hF, 0, 32'h804, '0);
        checkOutput("firstTieIf", 64'(lastExpIf), 64'h1);
        idleCycles(MEM_LATENCY + 1);

        $display("[TB] random traffic");
        ir = 0; dr = 0; ia = '0; da = '0; dwe = 0; dlk = 0; dbe = '0; dw = '0;
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) begin
                applyReset();
                ir = 0; dr = 0;
            end
            if (!(ir && !lastExpIf && $urandom_range(9) != 0)) begin
                ir = ($urandom_range(2) != 0);
                ia = $urandom;
            end
            if (!(dr && !lastExpD && $urandom_range(9) != 0)) begin
                dr  = ($urandom_range(2) != 0);
                dwe = $urandom_range(1);
                dlk = ($urandom_range(3) == 0);
                dbe = BE_W'($urandom);
                da  = $urandom;
                dw  = $urandom;
            end
            applyStimulus(ir, ia, dr, dwe, dbe, dlk, da, dw);
        end
        idleCycles(MEM_LATENCY + 1);
        checkOutput("drainQueue", 64'(pending.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
